norm_fifo_arbiter: RTL and testbench

NORM_FIFO_ARBITER -- requirements
Module: norm_fifo_arbiter

---
 rtl/norm_fifo_arbiter.sv | 175 +++++++++++++++++
 tb/tb_norm_fifo_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_fifo_arbiter.sv
// Round-robin reader for NUM_REQ tagged-normalized FIFOs feeding one output.
// Define NORM_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
`timescale 1ns/1ps
`ifndef TAG_SIZE
`define TAG_SIZE 4
`endif

package norm_arb_pkg;
    typedef struct packed {
        logic [`TAG_SIZE-1:0] tag;
        logic                 sign;
        logic [7:0]           exp;
        logic [22:0]          frac;
    } tagged_normalized_t;
endpackage

module norm_fifo_arbiter
    import norm_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TAG_SIZE       = `TAG_SIZE,
    parameter int TIMEOUT_CYCLES = 8,
    localparam int SRC_W         = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                req_read,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  tagged_normalized_t [NUM_REQ-1:0]  req_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output tagged_normalized_t                out_data,
    output logic [SRC_W-1:0]                  out_src,
    output logic [TAG_SIZE-1:0]               out_tag,
    output logic                              busy,
    output logic                              err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   rr_next;
    tagged_normalized_t out_data_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               grant_ld;
    logic               capture;
    logic               valid_g;
    logic               tmo_hit;

    function automatic logic [SRC_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] rdy,
        input logic [SRC_W-1:0]   last
    );
        logic [SRC_W-1:0] idx;
        logic [SRC_W-1:0] pick;
        logic             found;
        idx   = last;
        pick  = last;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == SRC_W'(NUM_REQ - 1))
                ? '0 : idx + SRC_W'(1);
            if (!found && rdy[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign rr_next = rr_pick(req_ready, last_grant);
    // last_grant doubles as g from grant until the next grant
    assign valid_g = req_valid[last_grant];

    always_comb begin
        state_d  = state_q;
        grant_ld = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    grant_ld = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (valid_g) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (|req_ready) begin
                        grant_ld = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_grant <= SRC_W'(NUM_REQ - 1);
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_ld) begin
                last_grant <= rr_next;
            end
            if (capture) begin
                out_data_q <= req_data[last_grant];
                out_src_q  <= last_grant;
            end
        end
    end

`ifdef NORM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    assign tmo_hit = (state_q == WAIT) && !valid_g
                  && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state_q != WAIT || tmo_hit) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    assign req_read  = (state_q == ISSUE)
                     ? (NUM_REQ'(1) << last_grant) : '0;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_tag   = TAG_SIZE'(out_data_q.tag);

endmodule

// File: tb/tb_norm_fifo_arbiter.sv
// Directed bench for norm_fifo_arbiter with a transaction-level reference model.
// Honours NORM_ARB_TIMEOUT_EN for the watchdog scenario.
`timescale 1ns/1ps
`ifndef TAG_SIZE
`define TAG_SIZE 4
`endif

module tb_norm_fifo_arbiter;
    import norm_arb_pkg::*;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int TW  = `TAG_SIZE;
    localparam int TMO = 8;
`ifdef NORM_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N-1:0]               req_ready;
    logic [N-1:0]               req_read;
    logic [N-1:0]               req_valid;
    tagged_normalized_t [N-1:0] req_data;
    logic                       out_valid;
    logic                       out_ready;
    tagged_normalized_t         out_data;
    logic [SW-1:0]              out_src;
    logic [TW-1:0]              out_tag;
    logic                       busy;
    logic                       err_timeout;

    norm_fifo_arbiter #(
        .NUM_REQ(N),
        .TAG_SIZE(TW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_ready(req_ready),
        .req_read(req_read),
        .req_valid(req_valid),
        .req_data(req_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_src(out_src),
        .out_tag(out_tag),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // model: phase 0 free, 1 read issued, 2 awaiting data, 3 holding entry
    int                 m_phase;
    int                 m_g;
    int                 m_last;
    int                 m_wait;
    int                 m_src;
    tagged_normalized_t m_data;
    bit                 m_err;

    int           checks;
    int           failures;
    int           cyc;
    int           vcount;
    bit           chk_en;
    bit           auto_resp;
    logic [N-1:0] rd_last;
    int           rd_idx[$];
    int           rd_cyc[$];
    tagged_normalized_t held;

    function automatic tagged_normalized_t mk(input int tag, input int i);
        tagged_normalized_t d;
        d.tag  = TW'(tag);
        d.sign = i[0];
        d.exp  = 8'(100 + i);
        d.frac = 23'(tag * 1000 + i);
        return d;
    endfunction

    function automatic int rr_next(input logic [N-1:0] rdy, input int last);
        logic [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            t = rdy >> ((last + k) % N);
            if (t[0]) return (last + k) % N;
        end
        return last;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] v;
        m_err = 1'b0;
        if (!reset) begin
            m_phase = 0;
            m_last  = N - 1;
            m_g     = 0;
            m_data  = '0;
            m_src   = 0;
            m_wait  = 0;
            return;
        end
        case (m_phase)
            0: if (req_ready != '0) begin
                m_g     = rr_next(req_ready, m_last);
                m_last  = m_g;
                m_phase = 1;
            end
            1: begin
                m_phase = 2;
                m_wait  = 0;
            end
            2: begin
                v = req_valid >> m_g;
                if (v[0]) begin
                    m_data  = req_data[m_g[SW-1:0]];
                    m_src   = m_g;
                    m_phase = 3;
                end else begin
                    m_wait++;
                    if (TMO_ON && m_wait >= TMO) begin
                        m_err   = 1'b1;
                        m_phase = 0;
                    end
                end
            end
            3: if (out_ready) begin
                if (req_ready != '0) begin
                    m_g     = rr_next(req_ready, m_last);
                    m_last  = m_g;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_loop();
        logic [N-1:0] er;
        forever begin
            @(negedge clk);
            cyc++;
            rd_last = req_read;
            if (chk_en) begin
                er = (m_phase == 1) ? (N'(1) << m_g) : '0;
                chk("m_read", 64'(req_read), 64'(er));
                chk("m_valid", 64'(out_valid), 64'(m_phase == 3));
                chk("m_busy", 64'(busy), 64'(m_phase != 0));
                chk("m_err", 64'(err_timeout), 64'(m_err));
                chk("m_data", 64'(out_data), 64'(m_data));
                chk("m_src", 64'(out_src), 64'(m_src));
                chk("m_tag", 64'(out_tag), 64'(m_data.tag));
                if (out_valid) vcount++;
                for (int i = 0; i < N; i++) begin
                    if (req_read[i]) begin
                        rd_idx.push_back(i);
                        rd_cyc.push_back(cyc);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (auto_resp) req_valid = rd_last;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        reset     = 1'b0;
        req_ready = '0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i] = mk(i + 5, i);
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        vcount    = 0;
        chk_en    = 1'b0;
        auto_resp = 1'b1;
        rd_last   = '0;
        m_phase   = 0;
        m_g       = 0;
        m_last    = N - 1;
        m_wait    = 0;
        m_src     = 0;
        m_data    = '0;
        m_err     = 1'b0;
        fork
            compare_loop();
        join_none

        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_read", 64'(req_read), 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);

        // single request latency
        reset = 1'b1;
        tick();
        req_ready = 4'b0001;
        tick();
        chk("s1_read", 64'(req_read), 64'h1);
        req_ready = '0;
        tick();
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_novalid", 64'(out_valid), 64'd0);
        tick();
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_src", 64'(out_src), 64'd0);
        chk("s1_tag", 64'(out_tag), 64'd5);
        out_ready = 1'b1;
        tick();
        chk("s1_idle", 64'(busy), 64'd0);

        // all requesters ready, consumer always ready
        do_reset();
        out_ready = 1'b1;
        req_ready = 4'b1111;
        rd_idx.delete();
        rd_cyc.delete();
        vcount = 0;
        repeat (14) tick();
        chk("s2_nreads", 64'(rd_idx.size()), 64'd5);
        chk("s2_nvalid", 64'(vcount), 64'd4);
        if (rd_idx.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("s2_order", 64'(rd_idx[k]), 64'(exp_order[k]));
            end
            for (int k = 0; k < 4; k++) begin
                chk("s2_gap", 64'(rd_cyc[k+1] - rd_cyc[k]), 64'd3);
            end
        end
        req_ready = '0;
        repeat (4) tick();

        // consumer stall in HOLD
        out_ready = 1'b0;
        req_ready = 4'b1111;
        repeat (3) tick();
        chk("s3_valid", 64'(out_valid), 64'd1);
        chk("s3_src", 64'(out_src), 64'd1);
        chk("s3_tag", 64'(out_tag), 64'd6);
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            chk("s3_stable", 64'(out_data), 64'(held));
            chk("s3_noread", 64'(req_read), 64'd0);
            tick();
        end
        chk("s3_still", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("s3_next", 64'(req_read), 64'h4);
        req_ready = '0;
        repeat (4) tick();

        // stray req_valid on a non-granted FIFO
        auto_resp = 1'b0;
        do_reset();
        req_data[0] = mk(9, 0);
        req_ready = 4'b0100;
        tick();
        chk("s4_read", 64'(req_read), 64'h4);
        req_ready = '0;
        tick();
        req_valid = 4'b0001;
        tick();
        chk("s4_stray", 64'(out_valid), 64'd0);
        chk("s4_busy", 64'(busy), 64'd1);
        req_valid = 4'b0100;
        tick();
        chk("s4_valid", 64'(out_valid), 64'd1);
        chk("s4_src", 64'(out_src), 64'd2);
        chk("s4_tag", 64'(out_tag), 64'd7);
        req_valid = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        req_data[0] = mk(5, 0);

        // missing req_valid
        do_reset();
        req_ready = 4'b0010;
        tick();
        chk("s5_read", 64'(req_read), 64'h2);
        req_ready = '0;
        tick();
`ifdef NORM_ARB_TIMEOUT_EN
        for (int k = 0; k < TMO; k++) begin
            chk("s5_noerr", 64'(err_timeout), 64'd0);
            chk("s5_busy", 64'(busy), 64'd1);
            tick();
        end
        chk("s5_err", 64'(err_timeout), 64'd1);
        chk("s5_idle", 64'(busy), 64'd0);
        req_ready = 4'b1111;
        auto_resp = 1'b1;
        tick();
        chk("s5_next", 64'(req_read), 64'h4);
        chk("s5_errgone", 64'(err_timeout), 64'd0);
`else
        for (int k = 0; k < 12; k++) begin
            chk("s5_stall", 64'(busy), 64'd1);
            chk("s5_noerr", 64'(err_timeout), 64'd0);
            tick();
        end
        req_valid = 4'b0010;
        tick();
        chk("s5_late", 64'(out_src), 64'd1);
        req_valid = '0;
        auto_resp = 1'b1;
`endif
        req_ready = '0;
        out_ready = 1'b1;
        repeat (4) tick();

        // reset in WAIT
        auto_resp = 1'b0;
        do_reset();
        req_ready = 4'b0001;
        tick();
        req_ready = '0;
        tick();
        chk("s6_wait", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        chk("s6_busy", 64'(busy), 64'd0);
        chk("s6_valid", 64'(out_valid), 64'd0);
        chk("s6_read", 64'(req_read), 64'd0);
        reset = 1'b1;
        req_valid = 4'b0001;
        tick();
        chk("s6_late", 64'(out_valid), 64'd0);
        chk("s6_idle", 64'(busy), 64'd0);
        req_valid = '0;
        tick();
        chk("s6_end", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
